// File: rtl/fft_stream_scoreboard.sv
// rtl/fft_stream_scoreboard.sv - AXI-Stream result checker comparing FFT output beats against a golden frame RAM
module fft_stream_scoreboard #(
  parameter int DWIDTH    = 32,
  parameter int MAX_POINT = 1024,
  parameter int PW        = $clog2(MAX_POINT) + 1,
  parameter int CW        = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_gold_we,
  input  logic [$clog2(MAX_POINT)-1:0] i_gold_addr,
  input  logic [DWIDTH-1:0]          i_gold_data,
  input  logic                       i_arm,
  input  logic [PW-1:0]              i_point,
  input  logic [9:0]                 i_frames,
  input  logic [DWIDTH/2-1:0]        i_tol,
  input  logic                       i_stall_en,
  input  logic [DWIDTH-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CW-1:0]              o_pass_cnt,
  output logic [CW-1:0]              o_err_cnt,
  output logic [PW-2:0]              o_first_err_idx,
  output logic [9:0]                 o_first_err_frame,
  output logic                       o_err_seen,
  output logic                       o_tlast_err
);
  localparam int AW = $clog2(MAX_POINT);
  localparam int HW = DWIDTH / 2;
  localparam logic [HW:0]   ONE_D   = 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [15:0]   SEED    = 16'hACE1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [DWIDTH-1:0] gold_mem [MAX_POINT];
  logic [AW-1:0]     beat_idx, last_idx;
  logic [9:0]        frame_cnt, last_frame;
  logic [HW-1:0]     tol_q;
  logic              stall_q;
  logic [15:0]       lfsr;
  logic [PW-1:0]     point_eff;
  logic [DWIDTH-1:0] gold_word;
  logic [HW:0]       diff_re, diff_im, abs_re, abs_im;
  logic              accept, beat_ok, at_last_idx, frame_end, run_end;

  always_ff @(posedge clk) begin
    if (i_gold_we && state == IDLE)
      gold_mem[i_gold_addr] <= i_gold_data;
  end

  always_comb begin
    point_eff = i_point;
    if (i_point == '0 || i_point > PW'(MAX_POINT))
      point_eff = PW'(MAX_POINT);
  end

  // Differences are taken one bit wider than a component so they never overflow.
  assign gold_word = gold_mem[beat_idx];
  assign diff_re   = {s_axis_tdata[DWIDTH-1], s_axis_tdata[DWIDTH-1:HW]}
                   - {gold_word[DWIDTH-1], gold_word[DWIDTH-1:HW]};
  assign diff_im   = {s_axis_tdata[HW-1], s_axis_tdata[HW-1:0]}
                   - {gold_word[HW-1], gold_word[HW-1:0]};
  assign abs_re    = diff_re[HW] ? (~diff_re + ONE_D) : diff_re;
  assign abs_im    = diff_im[HW] ? (~diff_im + ONE_D) : diff_im;
  assign beat_ok   = (abs_re <= {1'b0, tol_q}) && (abs_im <= {1'b0, tol_q});

  assign accept      = (state == RUN) && s_axis_tvalid && s_axis_tready;
  assign at_last_idx = (beat_idx == last_idx);
  assign frame_end   = s_axis_tlast || at_last_idx;
  assign run_end     = accept && frame_end && (frame_cnt == last_frame);

  always_comb begin
    state_nxt     = state;
    o_busy        = (state != IDLE);
    o_done        = (state == FLUSH);
    s_axis_tready = 1'b1;
    case (state)
      IDLE:    if (i_arm) state_nxt = RUN;
      RUN: begin
        if (stall_q) s_axis_tready = (lfsr[1:0] != 2'b00);
        if (run_end) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      beat_idx          <= '0;
      last_idx          <= '0;
      frame_cnt         <= '0;
      last_frame        <= '0;
      tol_q             <= '0;
      stall_q           <= 1'b0;
      lfsr              <= SEED;
      o_pass_cnt        <= '0;
      o_err_cnt         <= '0;
      o_first_err_idx   <= '0;
      o_first_err_frame <= '0;
      o_err_seen        <= 1'b0;
      o_tlast_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_arm) begin
        last_idx          <= AW'(point_eff - PW'(1));
        last_frame        <= (i_frames == 10'd0) ? 10'd0 : i_frames - 10'd1;
        tol_q             <= i_tol;
        stall_q           <= i_stall_en;
        lfsr              <= SEED;
        beat_idx          <= '0;
        frame_cnt         <= '0;
        o_pass_cnt        <= '0;
        o_err_cnt         <= '0;
        o_first_err_idx   <= '0;
        o_first_err_frame <= '0;
        o_err_seen        <= 1'b0;
        o_tlast_err       <= 1'b0;
      end else if (state == RUN) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (accept) begin
          if (beat_ok) begin
            if (o_pass_cnt != CNT_MAX) o_pass_cnt <= o_pass_cnt + CW'(1);
          end else begin
            if (o_err_cnt != CNT_MAX) o_err_cnt <= o_err_cnt + CW'(1);
            if (!o_err_seen) begin
              o_first_err_idx   <= beat_idx;
              o_first_err_frame <= frame_cnt;
              o_err_seen        <= 1'b1;
            end
          end
          // Early or missing tlast both close the frame; either is a framing error.
          if (s_axis_tlast != at_last_idx) o_tlast_err <= 1'b1;
          if (frame_end) begin
            beat_idx  <= '0;
            frame_cnt <= frame_cnt + 10'd1;
          end else begin
            beat_idx <= beat_idx + AW'(1);
          end
        end
      end
    end
  end
endmodule
